// File: rtl/cosim_constants_pkg.sv
// ============================================================================
// cosim_constants_pkg: base widths shared by the cosim packages.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cosim_constants_pkg;

  localparam int XLEN     = 32;
  localparam int FREG_W   = 64;
  localparam int REG_ID_W = 12;

endpackage

`default_nettype wire

// File: rtl/cosim_types_pkg.sv
// ============================================================================
// cosim_types_pkg: commit-log item types shared by the RTL collector and DPI side.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cosim_types_pkg;

  import cosim_constants_pkg::*;

  typedef logic [XLEN-1:0]     reg_t;
  typedef logic [FREG_W-1:0]   freg_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef enum logic [1:0] {
    XREG = 2'd0,
    FREG = 2'd1,
    VREG = 2'd2,
    CSR  = 2'd3
  } reg_key_type_e;

  typedef struct packed {
    reg_key_type_e reg_type;
    reg_id_t       id;
  } reg_key_t;

  typedef struct packed {
    reg_key_t key;
    freg_t    value;
  } commit_log_reg_item_t;

  localparam int CommitLogEntries = 16;

endpackage

`default_nettype wire

// File: rtl/commit_log_fifo.sv
// ============================================================================
// commit_log_fifo: parameterized synchronous FIFO, async active-low reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_log_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  T                   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign o_full  = (r_count == c_cnt_w'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_log_collector.sv
// ============================================================================
// commit_log_collector: packs DUT register writes and retires into commit packets.
// Optional feature macro COSIM_COLLECT_CSR_EN records CSR writes. Revision: 1.0
// ============================================================================
`default_nettype none

module commit_log_collector
  import cosim_types_pkg::*;
#(
  parameter int Entries = CommitLogEntries
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_valid_i,
  input  reg_key_t                     wr_key_i,
  input  freg_t                        wr_value_i,
  output logic                         wr_ready_o,
  input  logic                         retire_valid_i,
  input  reg_t                         retire_pc_i,
  output logic                         retire_ready_o,
  output logic                         hdr_valid_o,
  output reg_t                         hdr_pc_o,
  output logic [$clog2(Entries+1)-1:0] hdr_count_o,
  input  logic                         hdr_ready_i,
  output logic                         item_valid_o,
  output commit_log_reg_item_t         item_o,
  output logic                         item_last_o,
  input  logic                         item_ready_i,
  output logic                         ovf_o
);

  localparam int c_cnt_w = $clog2(Entries + 1);

  typedef struct packed {
    reg_t               pc;
    logic [c_cnt_w-1:0] count;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [c_cnt_w-1:0]   r_open_cnt;
  logic [c_cnt_w-1:0]   r_remain;
  logic [c_cnt_w-1:0]   w_remain_nxt;
  logic                 r_ovf;

  logic                 w_item_full;
  logic                 w_item_empty;
  logic                 w_instr_full;
  logic                 w_instr_empty;
  commit_log_reg_item_t w_item_in;
  commit_log_reg_item_t w_item_head;
  instr_t               w_instr_in;
  instr_t               w_instr_head;

  logic                 w_wr_filtered;
  logic                 w_at_limit;
  logic                 w_wr_fire;
  logic                 w_wr_record;
  logic                 w_wr_ovf;
  logic                 w_ret_fire;
  logic                 w_hdr_pop;
  logic                 w_item_pop;

`ifdef COSIM_COLLECT_CSR_EN
  assign w_wr_filtered = 1'b0;
`else
  assign w_wr_filtered = (wr_key_i.reg_type == CSR);
`endif

  // Once an instruction has filled its quota, further writes are swallowed
  // so the retire stage never stalls on a runaway instruction.
  assign w_at_limit     = (r_open_cnt == c_cnt_w'(Entries));
  assign wr_ready_o     = w_at_limit || !w_item_full;
  assign w_wr_fire      = wr_valid_i && wr_ready_o;
  assign w_wr_record    = w_wr_fire && !w_wr_filtered && !w_at_limit;
  assign w_wr_ovf       = w_wr_fire && !w_wr_filtered && w_at_limit;

  assign retire_ready_o = !w_instr_full && (!wr_valid_i || wr_ready_o);
  assign w_ret_fire     = retire_valid_i && retire_ready_o;

  assign w_item_in      = commit_log_reg_item_t'({wr_key_i, wr_value_i});
  assign w_instr_in.pc    = retire_pc_i;
  assign w_instr_in.count = r_open_cnt + c_cnt_w'(w_wr_record);

  assign ovf_o = r_ovf;

  commit_log_fifo #(
    .T     (commit_log_reg_item_t),
    .DEPTH (Entries)
  ) u_item_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_wr_record),
    .i_data  (w_item_in),
    .i_pop   (w_item_pop),
    .o_data  (w_item_head),
    .o_full  (w_item_full),
    .o_empty (w_item_empty)
  );

  commit_log_fifo #(
    .T     (instr_t),
    .DEPTH (Entries)
  ) u_instr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_ret_fire),
    .i_data  (w_instr_in),
    .i_pop   (w_hdr_pop),
    .o_data  (w_instr_head),
    .o_full  (w_instr_full),
    .o_empty (w_instr_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_open_cnt <= '0;
      r_ovf      <= 1'b0;
      r_state    <= ST_IDLE;
      r_remain   <= '0;
    end else begin
      if (w_ret_fire) begin
        r_open_cnt <= '0;
      end else if (w_wr_record) begin
        r_open_cnt <= r_open_cnt + c_cnt_w'(1);
      end
      if (w_wr_ovf) r_ovf <= 1'b1;
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  // Leaving IDLE on an accepted retire keeps push-to-header latency at one cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_hdr_pop    = 1'b0;
    w_item_pop   = 1'b0;
    hdr_valid_o  = 1'b0;
    hdr_pc_o     = '0;
    hdr_count_o  = '0;
    item_valid_o = 1'b0;
    item_o       = '0;
    item_last_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_instr_empty || w_ret_fire) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        hdr_valid_o = !w_instr_empty;
        hdr_pc_o    = w_instr_head.pc;
        hdr_count_o = w_instr_head.count;
        if (hdr_valid_o && hdr_ready_i) begin
          w_hdr_pop = 1'b1;
          if (w_instr_head.count != '0) begin
            w_state_nxt  = ST_DATA;
            w_remain_nxt = w_instr_head.count;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        item_valid_o = !w_item_empty;
        item_o       = w_item_head;
        item_last_o  = (r_remain == c_cnt_w'(1));
        if (item_valid_o && item_ready_i) begin
          w_item_pop   = 1'b1;
          w_remain_nxt = r_remain - c_cnt_w'(1);
          if (item_last_o) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_log_collector.sv
// ============================================================================
// tb_commit_log_collector: scoreboard bench for commit_log_collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_commit_log_collector;

  import cosim_types_pkg::*;

  localparam int N  = CommitLogEntries;
  localparam int CW = $clog2(N + 1);
`ifdef COSIM_COLLECT_CSR_EN
  localparam int CSR_CNT = 2;
`else
  localparam int CSR_CNT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 wr_valid_i = 1'b0;
  reg_key_t             wr_key_i = '0;
  freg_t                wr_value_i = '0;
  logic                 wr_ready_o;
  logic                 retire_valid_i = 1'b0;
  reg_t                 retire_pc_i = '0;
  logic                 retire_ready_o;
  logic                 hdr_valid_o;
  reg_t                 hdr_pc_o;
  logic [CW-1:0]        hdr_count_o;
  logic                 hdr_ready_i = 1'b1;
  logic                 item_valid_o;
  commit_log_reg_item_t item_o;
  logic                 item_last_o;
  logic                 item_ready_i = 1'b1;
  logic                 ovf_o;

  always #5 clk = ~clk;

  commit_log_collector #(.Entries(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .wr_valid_i     (wr_valid_i),
    .wr_key_i       (wr_key_i),
    .wr_value_i     (wr_value_i),
    .wr_ready_o     (wr_ready_o),
    .retire_valid_i (retire_valid_i),
    .retire_pc_i    (retire_pc_i),
    .retire_ready_o (retire_ready_o),
    .hdr_valid_o    (hdr_valid_o),
    .hdr_pc_o       (hdr_pc_o),
    .hdr_count_o    (hdr_count_o),
    .hdr_ready_i    (hdr_ready_i),
    .item_valid_o   (item_valid_o),
    .item_o         (item_o),
    .item_last_o    (item_last_o),
    .item_ready_i   (item_ready_i),
    .ovf_o          (ovf_o)
  );

  typedef struct {
    bit                   is_hdr;
    reg_t                 pc;
    logic [CW-1:0]        cnt;
    commit_log_reg_item_t item;
    bit                   last;
  } beat_t;

  beat_t                exp_q[$];
  commit_log_reg_item_t pend_q[$];
  int                   m_open = 0;
  int                   checks = 0;
  int                   failures = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name, int act, int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic reg_key_t k(reg_key_type_e t, int id);
    reg_key_t r;
    r.reg_type = t;
    r.id       = reg_id_t'(id);
    return r;
  endfunction

  task automatic model_write(reg_key_t key, freg_t v);
    commit_log_reg_item_t it;
    bit filt;
`ifdef COSIM_COLLECT_CSR_EN
    filt = 1'b0;
`else
    filt = (key.reg_type == CSR);
`endif
    it.key   = key;
    it.value = v;
    if (!filt && m_open < N) begin
      pend_q.push_back(it);
      m_open++;
    end
  endtask

  task automatic model_retire(reg_t pc);
    beat_t b;
    b.is_hdr = 1'b1;
    b.pc     = pc;
    b.cnt    = CW'(pend_q.size());
    b.item   = '0;
    b.last   = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < pend_q.size(); i++) begin
      b.is_hdr = 1'b0;
      b.item   = pend_q[i];
      b.last   = (i == pend_q.size() - 1);
      exp_q.push_back(b);
    end
    pend_q.delete();
    m_open = 0;
  endtask

  // One write and/or retire, held until the DUT accepts it.
  task automatic drive(bit wv, reg_key_t key, freg_t v, bit rv, reg_t pc);
    int n = 0;
    wr_valid_i     = wv;
    wr_key_i       = key;
    wr_value_i     = v;
    retire_valid_i = rv;
    retire_pc_i    = pc;
    forever begin
      @(negedge clk);
      if ((!wv || wr_ready_o) && (!rv || retire_ready_o)) break;
      n++;
      if (n > 50) begin
        fail_now("drive_timeout_cycles", n, 50);
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_valid_i     = 1'b0;
    retire_valid_i = 1'b0;
    if (wv) model_write(key, v);
    if (rv) model_retire(pc);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (hdr_valid_o && hdr_ready_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_hdr_queue_size", 0, 1);
          else begin
            e = exp_q.pop_front();
            if (!e.is_hdr) fail_now("hdr_where_item_due_is_hdr", 1, 0);
            else begin
              chk("hdr_pc", 128'(hdr_pc_o), 128'(e.pc));
              chk("hdr_count", 128'(hdr_count_o), 128'(e.cnt));
            end
          end
        end
        if (item_valid_o && item_ready_i) begin
          if (exp_q.size() == 0) fail_now("unexpected_item_queue_size", 0, 1);
          else begin
            e = exp_q.pop_front();
            if (e.is_hdr) fail_now("item_where_hdr_due_is_hdr", 0, 1);
            else begin
              chk("item", 128'(item_o), 128'(e.item));
              chk("item_last", 128'(item_last_o), 128'(e.last));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_valid", 128'(hdr_valid_o), 128'd0);
    chk("rst_item_valid", 128'(item_valid_o), 128'd0);
    chk("rst_item_last", 128'(item_last_o), 128'd0);
    chk("rst_ovf", 128'(ovf_o), 128'd0);
    chk("rst_hdr_pc", 128'(hdr_pc_o), 128'd0);
    chk("rst_hdr_count", 128'(hdr_count_o), 128'd0);
    chk("rst_item", 128'(item_o), 128'd0);
    chk("rst_wr_ready", 128'(wr_ready_o), 128'd1);
    chk("rst_retire_ready", 128'(retire_ready_o), 128'd1);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Header-only packet, visible one cycle after the retire.
    drive(1'b0, k(XREG, 0), '0, 1'b1, 32'h8000_0000);
    chk("t1_hdr_latency", 128'(hdr_valid_o), 128'd1);
    chk("t1_hdr_pc", 128'(hdr_pc_o), 128'h8000_0000);
    chk("t1_hdr_count", 128'(hdr_count_o), 128'd0);
    @(posedge clk);
    #1;
    chk("t1_idle_hdr_valid", 128'(hdr_valid_o), 128'd0);
    chk("t1_idle_item_valid", 128'(item_valid_o), 128'd0);
    wait_drain("t1_drain_left");

    // Three writes, the last one concurrent with the retire.
    drive(1'b1, k(XREG, 5), 64'h11, 1'b0, '0);
    drive(1'b1, k(FREG, 2), 64'h22, 1'b0, '0);
    drive(1'b1, k(XREG, 1), 64'h33, 1'b1, 32'h8000_0004);
    chk("t2_hdr_count", 128'(hdr_count_o), 128'd3);
    wait_drain("t2_drain_left");

    // Backpressure: fill the item FIFO across two instructions.
    item_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, k(XREG, i + 1), 64'h100 + 64'(i), 1'b0, '0);
    drive(1'b0, k(XREG, 0), '0, 1'b1, 32'h8000_0008);
    for (int i = 0; i < 8; i++) drive(1'b1, k(FREG, i), 64'h200 + 64'(i), 1'b0, '0);
    wr_valid_i     = 1'b1;
    wr_key_i       = k(XREG, 9);
    wr_value_i     = 64'h999;
    retire_valid_i = 1'b1;
    retire_pc_i    = 32'h8000_000c;
    @(negedge clk);
    chk("t3_wr_ready_full", 128'(wr_ready_o), 128'd0);
    chk("t3_retire_refused", 128'(retire_ready_o), 128'd0);
    #1 wr_valid_i = 1'b0;
    #1 chk("t3_retire_accepted", 128'(retire_ready_o), 128'd1);
    @(posedge clk);
    #1;
    retire_valid_i = 1'b0;
    model_retire(32'h8000_000c);
    item_ready_i = 1'b1;
    wait_drain("t3_drain_left");

    // Overflow: 17 writes in one instruction.
    chk("t4_ovf_before", 128'(ovf_o), 128'd0);
    for (int i = 0; i < 17; i++) drive(1'b1, k(XREG, i + 1), 64'h300 + 64'(i), 1'b0, '0);
    chk("t4_ovf_set", 128'(ovf_o), 128'd1);
    drive(1'b0, k(XREG, 0), '0, 1'b1, 32'h8000_0010);
    chk("t4_hdr_count", 128'(hdr_count_o), 128'(N));
    wait_drain("t4_drain_left");
    chk("t4_ovf_sticky", 128'(ovf_o), 128'd1);

    // CSR filtering depends on the build macro.
    drive(1'b1, k(CSR, 12'h300), 64'h1800, 1'b0, '0);
    drive(1'b1, k(XREG, 3), 64'h44, 1'b0, '0);
    drive(1'b0, k(XREG, 0), '0, 1'b1, 32'h8000_0014);
    chk("t5_csr_count", 128'(hdr_count_o), 128'(CSR_CNT));
    wait_drain("t5_drain_left");

    // Reset while a packet is stalled mid-drain.
    item_ready_i = 1'b0;
    drive(1'b1, k(XREG, 7), 64'h77, 1'b0, '0);
    drive(1'b1, k(XREG, 8), 64'h88, 1'b1, 32'h8000_0018);
    @(posedge clk);
    #1;
    chk("t6_stalled_item_valid", 128'(item_valid_o), 128'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_hdr_valid", 128'(hdr_valid_o), 128'd0);
    chk("t6_rst_item_valid", 128'(item_valid_o), 128'd0);
    chk("t6_rst_ovf", 128'(ovf_o), 128'd0);
    exp_q.delete();
    pend_q.delete();
    m_open = 0;
    @(posedge clk);
    #1;
    item_ready_i = 1'b1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_post_hdr_valid", 128'(hdr_valid_o), 128'd0);
    drive(1'b1, k(FREG, 4), 64'haa, 1'b0, '0);
    drive(1'b0, k(XREG, 0), '0, 1'b1, 32'h8000_001c);
    chk("t6_post_hdr_count", 128'(hdr_count_o), 128'd1);
    wait_drain("t6_drain_left");
    chk("t6_post_ovf", 128'(ovf_o), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_log_collector.md
# commit_log_collector

Captures the DUT's architectural register writes and instruction retirements into per-instruction commit packets. The cosim checker drains these packets and compares each one against the spike commit log (`get_log_reg_write`, `get_pc`) for the same step. It sits between the DUT retire stage (producer) and the checker (consumer). It is the DUT-side counterpart of the spike log: it produces, in hardware, the same item format that the DPI path returns.

## Interface
- `Entries`, default 16 (`CommitLogEntries`): depth of the item FIFO and of the instruction FIFO; also the maximum number of writes per instruction.
- `clk_i` input, 1: clock.
- `rst_ni` input, 1: reset, asynchronous, active-low.
- `wr_valid_i` input, 1: the DUT presents one register write.
- `wr_key_i` input, `reg_key_t`: register type and id.
- `wr_value_i` input, `freg_t`: written value, zero-extended to `FREG_W`.
- `wr_ready_o` output, 1: the write is accepted when `wr_valid_i && wr_ready_o`.
- `retire_valid_i` input, 1: the current instruction retires; it closes its packet.
- `retire_pc_i` input, `reg_t`: PC of the retiring instruction.
- `retire_ready_o` output, 1: the retire is accepted when `retire_valid_i && retire_ready_o`.
- `hdr_valid_o` output, 1: a packet header is presented.
- `hdr_pc_o` output, `reg_t`: header field, PC of the packet's instruction.
- `hdr_count_o` output, `$clog2(Entries+1)`: header field, number of items in the packet.
- `hdr_ready_i` input, 1: the checker accepts the header.
- `item_valid_o` output, 1: an item is presented.
- `item_o` output, `commit_log_reg_item_t`: current item.
- `item_last_o` output, 1: the current item is the last one of its packet.
- `item_ready_i` input, 1: the checker accepts the item.
- `ovf_o` output, 1: sticky; an instruction attempted more than `Entries` writes.

## Operation
- **Item FIFO**
  - Holds `{wr_key_i, wr_value_i}`.
  - `wr_ready_o = !item_full`.
- **Open counter `open_cnt`**
  - Counts the writes accepted since the last accepted retire.
- **Writes beyond `Entries`**
  - A write arriving while `open_cnt == Entries` is accepted (`wr_ready_o` forced to 1) but discarded.
  - Such a write sets `ovf_o`; `ovf_o` is cleared only by reset.
- **Instruction FIFO**
  - Holds `{pc, count}` per retired instruction.
  - `retire_ready_o = !instr_full && (!wr_valid_i || wr_ready_o)`.
- **Write and retire in the same cycle**
  - A write accepted in the same cycle as a retire belongs to the retiring instruction.
  - The pushed count is `open_cnt + 1`, and `open_cnt` is then cleared to 0.
- **Retire without writes**
  - Pushes `count = 0`. The packet is a header only.
- **Output FSM states**
  - `IDLE`: waits for the instruction FIFO to be non-empty, then goes to `HDR`.
  - `HDR`: drives `hdr_valid_o` with the FIFO head. On `hdr_ready_i`, pops the head. Goes to `DATA` if count > 0, otherwise to `IDLE`.
  - `DATA`: streams exactly `count` items from the item FIFO. `item_last_o` is asserted when the remaining count is 1. On the last handshake, goes to `IDLE`.
- **FIFO invariant**
  - Items of a packet are always already present when its header is popped.
  - `item_valid_o` in `DATA` is therefore always 1. Seeing it low in `DATA` is a design error.
- **Reset values**
  - FSM is in `IDLE`; both FIFOs are empty; `open_cnt = 0`.
  - `hdr_valid_o = 0`, `item_valid_o = 0`, `item_last_o = 0`, `ovf_o = 0`.
  - `hdr_pc_o = 0`, `hdr_count_o = 0`, `item_o = 0`.
  - `wr_ready_o` and `retire_ready_o` reflect the empty FIFOs (1). Handshakes are ignored while `rst_ni = 0`.
- **Reset mid-packet**
  - All state is discarded, including any partially drained packet and `open_cnt`.

## Timing
- Push to output latency is 1 cycle: a retire accepted at edge N gives `hdr_valid_o` high after edge N, and the header is observable in the cycle following that edge.
- The FSM consumes one cycle for `HDR` and then one cycle per item in `DATA`. The idle-to-idle minimum is `count + 1` cycles.
- `ready` signals are combinational from the registered FIFO state and `wr_valid_i`.
- There is no combinational path from `hdr_ready_i` or `item_ready_i` to the input-side readies.
- A simultaneous pop and push on a full FIFO is not allowed: `full` blocks the push for that cycle.

## Configuration
- Macro: `COSIM_COLLECT_CSR_EN`.
- Defined: writes with `reg_type == CSR` are recorded like any other write.
- Undefined:
  - CSR writes are accepted (`wr_ready_o` unaffected by them) and discarded.
  - They do not increment `open_cnt` and do not set `ovf_o`.
  - This matches checkers that filter CSR entries from the spike log.

## Structure
- Shared synthesizable package `cosim_types_pkg`, built on `cosim_constants_pkg`:
  - `reg_t`, `freg_t`, `reg_key_type_e`, `reg_id_t`, `reg_key_t`, `commit_log_reg_item_t`.
  - `CommitLogEntries`.
- The DPI package re-exports these types.
- One sub-module, `commit_log_fifo`: a parameterized synchronous FIFO (type, depth; full/empty flags; async active-low reset).
- `commit_log_fifo` is instantiated twice: item FIFO and instruction FIFO.

## Test plan
- **Header-only packet:** retire with pc=0x80000000 and no writes -> header `{0x80000000, 0}` appears 1 cycle later; no items follow; FSM returns to `IDLE`.
- **Three writes, last concurrent with retire:** XREG x5=0x11, FREG f2=0x22, then XREG x1=0x33 in the same cycle as retire pc=0x80000004 -> header count 3; items appear in order; `item_last_o` only on x1.
- **Backpressure on the item FIFO:** hold `item_ready_i = 0` and push 16 writes -> `wr_ready_o = 0`. A retire that cycle with `wr_valid_i = 1` is refused, while a retire with `wr_valid_i = 0` is accepted.
- **Overflow:** 17 writes in a single instruction with the checker draining -> 16 items delivered; `ovf_o = 1` and stays 1.
- **CSR filtering:** with the macro undefined, CSR mstatus write plus XREG x3 write, then retire -> count 1. With the macro defined -> count 2.
- **Reset mid-packet:** assert `rst_ni` mid-packet -> next cycle all valids are 0 and `ovf_o = 0`; subsequent packets are correct.
